// File: rtl/instr_mem_loadable.sv
// Byte-addressed little-endian instruction memory with a registered fetch port
// and a byte-serial run-time loader. The RUN/LOAD controller keeps fetch and load apart.
module instr_mem_loadable #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_INSTR   = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [7:0]        load_data,
  input  logic              load_done,
  output logic              loading,
  output logic [ADDR_W-1:0] load_count,
  output logic              load_ovf
);
  localparam int PTR_W = $clog2(DEPTH_BYTES);
  // Full-width bound so upper address bits can never alias into the array.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - 4);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } fetch_rsp_t;

  state_t           state, state_nxt;
  fetch_rsp_t       rsp, rsp_nxt;
  logic [7:0]       mem [DEPTH_BYTES];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic [31:0]      word;
  logic             legal;
  logic             wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // load_start dominates load_done so a restart always clears the pointer.
  always_comb begin
    state_nxt = state;
    if (load_start)                      state_nxt = LOAD;
    else if (state == LOAD && load_done) state_nxt = RUN;
  end

  always_comb begin
    loading = (state == LOAD);
    wr_en   = (state == LOAD) && load_we && !load_start;
  end

  always_comb begin
    idx   = fetch_addr[PTR_W-1:0];
    legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= MAX_ADDR);
    word  = {mem[idx + PTR_W'(3)], mem[idx + PTR_W'(2)], mem[idx + PTR_W'(1)], mem[idx]};
  end

  always_comb begin
    rsp_nxt = rsp;
    if (load_start || state == LOAD) begin
      rsp_nxt = '{instr: NOP_INSTR, valid: 1'b0, fault: 1'b0};
    end else if (!stall) begin
      if (!fetch_req)  rsp_nxt = '{instr: rsp.instr, valid: 1'b0, fault: 1'b0};
      else if (legal)  rsp_nxt = '{instr: word,      valid: 1'b1, fault: 1'b0};
      else             rsp_nxt = '{instr: NOP_INSTR, valid: 1'b0, fault: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp <= '{instr: NOP_INSTR, valid: 1'b0, fault: 1'b0};
    else        rsp <= rsp_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else if (load_start) begin
      ptr        <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else if (wr_en) begin
      ptr        <= ptr + PTR_W'(1);
      load_count <= load_count + ADDR_W'(1);
      if (ptr == PTR_W'(DEPTH_BYTES - 1)) load_ovf <= 1'b1;
    end
  end

  // Array is deliberately not reset so a reset mid-load keeps what was written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= load_data;
  end

  assign instr_out   = rsp.instr;
  assign instr_valid = rsp.valid;
  assign fault       = rsp.fault;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a spec-level model checked every cycle,
// plus literal expectations at key points.
module tb_instr_mem_loadable;
  localparam int AW = 32;
  localparam int DB = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req, stall, load_start, load_we, load_done;
  logic [AW-1:0] fetch_addr;
  logic [7:0]    load_data;
  logic [31:0]   instr_out;
  logic          instr_valid, fault, loading, load_ovf;
  logic [AW-1:0] load_count;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  instr_mem_loadable #(.ADDR_W(AW), .DEPTH_BYTES(DB), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .instr_out(instr_out), .instr_valid(instr_valid), .fault(fault),
    .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_done(load_done),
    .loading(loading), .load_count(load_count), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  // Model state in plain terms: a byte array, a write index and a mode flag.
  logic [7:0]  m_mem [DB];
  int          m_ptr, m_cnt;
  bit          m_load, m_ovf, m_valid, m_fault;
  logic [31:0] m_instr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 0; m_ptr <= 0; m_cnt <= 0; m_ovf <= 0;
      m_instr <= 32'h0; m_valid <= 0; m_fault <= 0;
    end else if (load_start) begin
      m_load <= 1; m_ptr <= 0; m_cnt <= 0; m_ovf <= 0;
      m_instr <= 32'h0; m_valid <= 0; m_fault <= 0;
    end else if (m_load) begin
      if (load_we) begin
        m_mem[m_ptr] <= load_data;
        m_ptr <= (m_ptr + 1) % DB;
        m_cnt <= m_cnt + 1;
        if (m_ptr == DB - 1) m_ovf <= 1;
      end
      if (load_done) m_load <= 0;
      m_instr <= 32'h0; m_valid <= 0; m_fault <= 0;
    end else if (!stall) begin
      if (!fetch_req) begin
        m_valid <= 0; m_fault <= 0;
      end else if (fetch_addr % 4 == 0 && fetch_addr <= DB - 4) begin
        m_instr <= {m_mem[fetch_addr+3], m_mem[fetch_addr+2], m_mem[fetch_addr+1], m_mem[fetch_addr]};
        m_valid <= 1; m_fault <= 0;
      end else begin
        m_instr <= 32'h0; m_valid <= 0; m_fault <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_instr", instr_out, m_instr);
      chk("m_valid", 32'(instr_valid), 32'(m_valid));
      chk("m_fault", 32'(fault), 32'(m_fault));
      chk("m_loading", 32'(loading), 32'(m_load));
      chk("m_count", load_count, 32'(m_cnt));
      chk("m_ovf", 32'(load_ovf), 32'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic idle();
    fetch_req = 0; stall = 0; load_start = 0; load_we = 0; load_done = 0;
    fetch_addr = '0; load_data = '0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_req = 1; fetch_addr = a; step(); fetch_req = 0;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 8'hFF);
  endfunction

  logic [7:0] prog [8];

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'hE8; prog[3] = 8'h00;
    prog[4] = 8'h22; prog[5] = 8'h08; prog[6] = 8'hE8; prog[7] = 8'h00;
    idle();
    rst_n = 0;
    step(2);
    rst_n = 1;
    run_cmp = 1;
    step();
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_loading", 32'(loading), 32'h0);
    chk("rst_count", load_count, 32'h0);

    // Overflow load: 257 bytes, last wraps onto m[0].
    load_start = 1; step(); load_start = 0;
    chk("ld_loading", 32'(loading), 32'h1);
    for (int i = 0; i < 257; i++) begin
      load_we = 1; load_data = (i == 256) ? 8'hA5 : pat(i); step();
    end
    load_we = 0;
    chk("ovf_count", load_count, 32'd257);
    chk("ovf_flag", 32'(load_ovf), 32'h1);
    load_done = 1; step(); load_done = 0;
    chk("done_loading", 32'(loading), 32'h0);

    fetch(32'h0);
    chk("wrap_m0", instr_out, 32'h18110AA5);
    fetch(32'hFC);
    chk("top_word", instr_out, 32'hFCF5EEE7);
    chk("top_valid", 32'(instr_valid), 32'h1);
    fetch(32'h2);
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_instr", instr_out, 32'h0);
    chk("mis_valid", 32'(instr_valid), 32'h0);
    fetch(32'h100);
    chk("oor_fault", 32'(fault), 32'h1);
    fetch(32'h8000_0000);
    chk("alias_fault", 32'(fault), 32'h1);
    fetch(32'hFD);
    step();

    // Program load; last byte shares the cycle with load_done.
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 8; i++) begin
      load_we = 1; load_data = prog[i]; load_done = (i == 7); step();
    end
    load_we = 0; load_done = 0;
    chk("prog_loading", 32'(loading), 32'h0);
    chk("prog_count", load_count, 32'd8);
    fetch(32'h0);
    chk("prog_w0", instr_out, 32'h00E80820);
    fetch(32'h4);
    chk("prog_w4", instr_out, 32'h00E80822);

    // Stall holds the word at 0 while the PC moves on.
    fetch(32'h0);
    fetch_req = 1; fetch_addr = 32'h4; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", instr_out, 32'h00E80820);
    end
    stall = 0; step(); fetch_req = 0;
    chk("stall_rel", instr_out, 32'h00E80822);

    // load_we in RUN is ignored.
    load_we = 1; load_data = 8'h77; step(); load_we = 0;
    fetch(32'h0);
    chk("run_we_ign", instr_out, 32'h00E80820);

    // load_start+load_done+load_we together: LOAD, cleared, byte discarded.
    load_start = 1; load_done = 1; load_we = 1; load_data = 8'h55; step();
    idle();
    chk("col_loading", 32'(loading), 32'h1);
    chk("col_count", load_count, 32'h0);
    fetch(32'h0);
    chk("load_fetch_ign", 32'(instr_valid), 32'h0);
    load_done = 1; step(); load_done = 0;
    fetch(32'h0);
    chk("col_discard", instr_out, 32'h00E80820);

    // Async reset mid-load keeps bytes already written.
    load_start = 1; step(); load_start = 0;
    load_we = 1; load_data = 8'h11; step();
    load_data = 8'h22; step(); load_we = 0;
    fetch_req = 1;
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("arst_loading", 32'(loading), 32'h0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_count", load_count, 32'h0);
    idle();
    step();
    rst_n = 1;
    fetch(32'h0);
    chk("arst_keep", instr_out, 32'h00E82211);
    step(2);
    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
